// File: rtl/cordic_vector_8bit_if.sv
// Handshake bundle for the vectoring CORDIC: vector in, angle/magnitude/flip out.
// The master modport drives the inputs; the slave modport is the core's side.
interface cordic_vector_8bit_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x_in;
  logic signed [7:0] y_in;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] angle_out;
  logic        [7:0] mag_out;
  logic              flip_out;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, angle_out, mag_out, flip_out
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, angle_out, mag_out, flip_out
  );
endinterface

// File: rtl/cordic_vector_8bit.sv
// Iterative vectoring CORDIC: one micro-rotation per clock, returning atan2(y,x) folded
// into [-pi/2, +pi/2] plus a flip flag, and the gain-compensated magnitude.
module cordic_vector_8bit #(
  parameter int ITERATIONS = 10,
  parameter int XY_W       = 20
) (
  input logic                 clk,
  input logic                 rst,   // active-low, asynchronous
  cordic_vector_8bit_if.slave bus
);

  localparam int             Z_W  = 18;
  localparam int             P_W  = XY_W + 11;
  localparam logic [3:0]     LAST = 4'(ITERATIONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCALE, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_iter;
  logic signed [XY_W-1:0]  r_x;
  logic signed [XY_W-1:0]  r_y;
  logic signed [Z_W-1:0]   r_z;
  logic                    r_flip;
  logic                    r_zero;
  logic signed [7:0]       r_angle;
  logic [7:0]              r_mag;
  logic                    r_flip_out;

  logic                    w_in_ready;
  logic                    w_out_valid;
  logic                    w_accept;
  logic signed [XY_W-1:0]  w_x_ext;
  logic signed [XY_W-1:0]  w_y_ext;
  logic signed [XY_W-1:0]  w_xs;
  logic signed [XY_W-1:0]  w_ys;
  logic signed [Z_W-1:0]   w_atan;
  logic signed [XY_W-1:0]  w_x_nxt;
  logic signed [XY_W-1:0]  w_y_nxt;
  logic signed [Z_W-1:0]   w_z_nxt;

  // atan(2^-i) in S1.16, truncated toward zero
  function automatic logic signed [Z_W-1:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    atan_lut = 18'sd51471;
      4'd1:    atan_lut = 18'sd30385;
      4'd2:    atan_lut = 18'sd16054;
      4'd3:    atan_lut = 18'sd8149;
      4'd4:    atan_lut = 18'sd4090;
      4'd5:    atan_lut = 18'sd2047;
      4'd6:    atan_lut = 18'sd1023;
      4'd7:    atan_lut = 18'sd511;
      4'd8:    atan_lut = 18'sd255;
      4'd9:    atan_lut = 18'sd127;
      default: atan_lut = 18'sd0;
    endcase
  endfunction

  // S1.16 -> S1.6, round half up, saturate on signed overflow
  function automatic logic signed [7:0] round_angle(input logic signed [Z_W-1:0] z);
    logic signed [Z_W:0] s;
    logic signed [8:0]   r;
    s = 19'(z) + 19'sd512;
    r = s[Z_W:10];
    if (r > 9'sd127)       round_angle = 8'sh7F;
    else if (r < -9'sd128) round_angle = -8'sd128;
    else                   round_angle = r[7:0];
  endfunction

  // x * 311/512 gain compensation, S3.16 -> U1.7 with rounding, clamp to [0, 0xFF]
  function automatic logic [7:0] scale_mag(input logic signed [XY_W-1:0] x);
    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] q;
    prod = P_W'(x) * P_W'(311);
    prod = prod + P_W'(1 << 17);
    q    = prod >>> 18;
    if (q[P_W-1])             scale_mag = 8'h00;
    else if (q > P_W'(255))   scale_mag = 8'hFF;
    else                      scale_mag = q[7:0];
  endfunction

  assign w_x_ext = {{(XY_W-16){bus.x_in[7]}}, bus.x_in[6:0], 9'b0};
  assign w_y_ext = {{(XY_W-16){bus.y_in[7]}}, bus.y_in[6:0], 9'b0};
  assign w_accept = bus.in_valid && w_in_ready;

  // micro-rotation: drive y toward zero, both updates from pre-iteration x/y
  always_comb begin
    w_xs   = r_x >>> r_iter;
    w_ys   = r_y >>> r_iter;
    w_atan = atan_lut(r_iter);
    if (!r_y[XY_W-1]) begin
      w_x_nxt = r_x + w_ys;
      w_y_nxt = r_y - w_xs;
      w_z_nxt = r_z + w_atan;
    end else begin
      w_x_nxt = r_x - w_ys;
      w_y_nxt = r_y + w_xs;
      w_z_nxt = r_z - w_atan;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_iter  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_iter  <= (r_state == S_RUN) ? r_iter + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)          w_state_nxt = S_RUN;
      S_RUN:   if (r_iter == LAST)    w_state_nxt = S_SCALE;
      S_SCALE:                        w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready)     w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == S_IDLE) && rst;
    w_out_valid = (r_state == S_DONE);
  end

  // Left half-plane inputs are mirrored through the origin so the iteration converges.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_x    <= bus.x_in[7] ? -w_x_ext : w_x_ext;
      r_y    <= bus.x_in[7] ? -w_y_ext : w_y_ext;
      r_z    <= '0;
      r_flip <= bus.x_in[7];
      r_zero <= (bus.x_in == 8'sd0) && (bus.y_in == 8'sd0);
    end else if (r_state == S_RUN) begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
      r_z <= w_z_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_angle    <= '0;
      r_mag      <= '0;
      r_flip_out <= 1'b0;
    end else if (r_state == S_SCALE) begin
      r_angle    <= r_zero ? 8'sd0 : round_angle(r_z);
      r_mag      <= r_zero ? 8'd0  : scale_mag(r_x);
      r_flip_out <= r_zero ? 1'b0  : r_flip;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.angle_out = r_angle;
  assign bus.mag_out   = r_mag;
  assign bus.flip_out  = r_flip_out;

endmodule

// File: tb/tb_cordic_vector_8bit.sv
// Directed bench for cordic_vector_8bit: hand-computed angle/magnitude vectors,
// latency, back-pressure, accept spacing and asynchronous reset mid-operation.
module tb_cordic_vector_8bit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errs;
  int   cycle;
  int   acc_q[$];

  cordic_vector_8bit_if bus ();

  cordic_vector_8bit #(.ITERATIONS(10), .XY_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle++;
    if (bus.in_valid && bus.in_ready) acc_q.push_back(cycle);
  end

  task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
    int d;
    n_checks++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    int k;
    k = 0;
    while (!bus.in_ready && k < 40) begin
      @(posedge clk); #1; k++;
    end
    check("send_ready", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    bus.y_in     = y;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.x_in     = 8'h55;
    bus.y_in     = 8'hAA;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic check_out(input string tag, input int ang, input int mag,
                           input int flip, input int tol);
    check({tag, "_angle"}, int'(bus.angle_out), ang, tol);
    check({tag, "_mag"},   int'(bus.mag_out),   mag, tol);
    check({tag, "_flip"},  int'(bus.flip_out),  flip);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("drain_out_valid", int'(bus.out_valid), 0);
  endtask

  task automatic run_vec(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input int ang, input int mag, input int flip, input int tol);
    int cyc;
    send(x, y);
    check({tag, "_busy"}, int'(bus.in_ready), 0);
    wait_valid(cyc);
    check({tag, "_latency"}, cyc, 11);
    check_out(tag, ang, mag, flip, tol);
    drain();
  endtask

  initial begin
    int cyc;
    int n0;
    int k;
    int hits;
    n_checks      = 0;
    n_errs        = 0;
    cycle         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  int'(bus.in_ready),  0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check_out("rst", 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("idle_in_ready", int'(bus.in_ready), 1);

    run_vec("x40_y00", 8'h40, 8'h00,    0,  64, 0, 1);
    run_vec("x40_y40", 8'h40, 8'h40,   50,  90, 0, 1);
    run_vec("x00_y7f", 8'h00, 8'h7F,  100, 127, 0, 1);
    run_vec("xc0_y00", 8'hC0, 8'h00,    0,  64, 1, 1);
    run_vec("x80_y80", 8'h80, 8'h80,   50, 181, 1, 1);
    run_vec("x00_y00", 8'h00, 8'h00,    0,   0, 0, 0);
    run_vec("x40_yc0", 8'h40, 8'hC0,  -50,  90, 0, 1);
    run_vec("x7f_y00", 8'h7F, 8'h00,    0, 127, 0, 1);
    run_vec("x00_y80", 8'h00, 8'h80, -100, 128, 0, 1);
    run_vec("xc0_y40", 8'hC0, 8'h40,  -50,  90, 1, 1);

    // back-pressure: result must hold and no accept while DONE
    send(8'h40, 8'h40);
    wait_valid(cyc);
    n0 = acc_q.size();
    bus.in_valid = 1'b1;
    bus.x_in     = 8'h7F;
    bus.y_in     = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", int'(bus.out_valid), 1);
      check("hold_in_ready",  int'(bus.in_ready),  0);
      check_out("hold", 50, 90, 0, 1);
    end
    check("hold_no_accept", acc_q.size(), n0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", int'(bus.out_valid), 0);
    check("release_in_ready",  int'(bus.in_ready),  1);
    @(posedge clk); #1;
    check("b2b_first_accept", acc_q.size(), n0 + 1);
    wait_valid(cyc);
    check("b2b_latency", cyc, 11);
    check_out("b2b_a", 0, 127, 0, 1);
    n0 = acc_q.size();
    k  = 0;
    while (acc_q.size() == n0 && k < 5) begin
      @(posedge clk); #1; k++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_second_accept", acc_q.size(), n0 + 1);
    if (acc_q.size() >= 2) check("b2b_spacing", acc_q[$] - acc_q[$-1], 13);
    wait_valid(cyc);
    check_out("b2b_b", 0, 127, 0, 1);
    drain();

    // asynchronous reset in the middle of iteration 4
    send(8'hC0, 8'h40);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst_out_valid", int'(bus.out_valid), 0);
    check("arst_in_ready",  int'(bus.in_ready),  0);
    check_out("arst", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) hits++;
    end
    check("arst_no_stale", hits, 0);
    run_vec("x20_y60", 8'h20, 8'h60, 80, 101, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d, expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
